sensor_uart_scheduler: RTL and testbench

SENSOR_UART_SCHEDULER -- requirements
Module: sensor_uart_scheduler

---
 rtl/sensor_uart_pkg.sv | 18 +
 rtl/sensor_uart_timer.sv | 27 ++
 rtl/sensor_uart_scheduler.sv | 152 +++++++++++++++
 tb/tb_sensor_uart_scheduler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_uart_pkg.sv
// Shared types and constants for the sensor UART command scheduler.
package sensor_uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDecode,
    StWaitFifo,
    StRstPulse,
    StSend
  } state_e;

  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  localparam int unsigned DATA_CMD_BASE_DEF = 97;
  localparam int unsigned RST_CMD_BASE_DEF  = 105;

endpackage

// File: rtl/sensor_uart_timer.sv
// Clearable up-counter with a done flag; times both the FIFO wait and the reset pulse.
module sensor_uart_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic [Width-1:0] i_target,
  output logic             o_done
);

  logic [Width-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_done = (r_count == i_target);

endmodule

// File: rtl/sensor_uart_scheduler.sv
// Decodes UART command bytes into sensor FIFO reads or sensor reset pulses and
// returns one response byte (data, ACK or NAK) per command.
module sensor_uart_scheduler
  import sensor_uart_pkg::*;
#(
  parameter int unsigned DATA_DEPTH       = 8,
  parameter int unsigned NUM_SENSORS      = 8,
  parameter int unsigned DATA_CMD_BASE    = DATA_CMD_BASE_DEF,
  parameter int unsigned RST_CMD_BASE     = RST_CMD_BASE_DEF,
  parameter int unsigned TIMEOUT_CYCLES   = 1000,
  parameter int unsigned RST_PULSE_CYCLES = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [DATA_DEPTH-1:0]             i_rx_data,
  input  logic                              i_rx_valid,
  output logic                              o_rx_ready,
  output logic [DATA_DEPTH-1:0]             o_tx_data,
  output logic                              o_tx_valid,
  input  logic                              i_tx_ready,
  input  logic [NUM_SENSORS-1:0]            i_fifo_valid,
  input  logic [NUM_SENSORS*DATA_DEPTH-1:0] i_fifo_data,
  output logic [NUM_SENSORS-1:0]            o_fifo_pop,
  output logic [NUM_SENSORS-1:0]            o_sensor_rst
);

  localparam int unsigned IdxW   = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
  localparam int unsigned MaxCnt = (TIMEOUT_CYCLES > RST_PULSE_CYCLES) ?
                                   TIMEOUT_CYCLES : RST_PULSE_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  state_e                  r_state, w_state_next;
  logic [DATA_DEPTH-1:0]   r_rx_byte;
  logic [DATA_DEPTH-1:0]   r_tx_data, w_tx_data_next;
  logic [IdxW-1:0]         r_idx, w_idx_next;
  logic [NUM_SENSORS-1:0]  r_fifo_pop, w_fifo_pop_next;
  logic                    w_rx_ready;
  logic                    w_timer_clear, w_timer_en, w_timer_done;
  logic [CntW-1:0]         w_timer_target;
  logic [31:0]             w_byte_ext;
  logic                    w_in_data, w_in_rst;
  logic                    w_head_valid;
  logic [DATA_DEPTH-1:0]   w_head;
  logic [NUM_SENSORS-1:0]  w_idx_onehot;

  // Unsigned range checks against the command bases; data range wins on overlap.
  assign w_byte_ext = 32'(r_rx_byte);
  assign w_in_data  = (w_byte_ext >= DATA_CMD_BASE) &&
                      (w_byte_ext < DATA_CMD_BASE + NUM_SENSORS);
  assign w_in_rst   = (w_byte_ext >= RST_CMD_BASE) &&
                      (w_byte_ext < RST_CMD_BASE + NUM_SENSORS);

  assign w_head_valid = i_fifo_valid[r_idx];
  assign w_head       = i_fifo_data[int'(r_idx)*DATA_DEPTH +: DATA_DEPTH];
  assign w_idx_onehot = NUM_SENSORS'(1) << r_idx;

  assign w_rx_ready     = (r_state == StIdle) && !i_rst;
  assign w_timer_target = (r_state == StRstPulse) ? CntW'(RST_PULSE_CYCLES - 1) :
                                                    CntW'(TIMEOUT_CYCLES - 1);

  sensor_uart_timer #(
    .Width (CntW)
  ) u_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (w_timer_clear),
    .i_en     (w_timer_en),
    .i_target (w_timer_target),
    .o_done   (w_timer_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_idx_next      = r_idx;
    w_tx_data_next  = r_tx_data;
    w_fifo_pop_next = '0;
    w_timer_clear   = 1'b0;
    w_timer_en      = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_rx_valid && w_rx_ready) w_state_next = StDecode;
      end
      StDecode: begin
        w_timer_clear = 1'b1;
        if (w_in_data) begin
          w_idx_next   = IdxW'(w_byte_ext - DATA_CMD_BASE);
          w_state_next = StWaitFifo;
        end else if (w_in_rst) begin
          w_idx_next   = IdxW'(w_byte_ext - RST_CMD_BASE);
          w_state_next = StRstPulse;
        end else begin
          w_tx_data_next = DATA_DEPTH'(NAK_BYTE);
          w_state_next   = StSend;
        end
      end
      StWaitFifo: begin
        // A FIFO that turns valid on the last wait cycle still takes the data path.
        if (w_head_valid) begin
          w_tx_data_next  = w_head;
          w_fifo_pop_next = w_idx_onehot;
          w_state_next    = StSend;
        end else if (w_timer_done) begin
          w_tx_data_next = DATA_DEPTH'(NAK_BYTE);
          w_state_next   = StSend;
        end else begin
          w_timer_en = 1'b1;
        end
      end
      StRstPulse: begin
        if (w_timer_done) begin
          w_tx_data_next = DATA_DEPTH'(ACK_BYTE);
          w_state_next   = StSend;
        end else begin
          w_timer_en = 1'b1;
        end
      end
      StSend: begin
        if (i_tx_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_byte  <= '0;
      r_tx_data  <= '0;
      r_idx      <= '0;
      r_fifo_pop <= '0;
    end else begin
      if (i_rx_valid && w_rx_ready) r_rx_byte <= i_rx_data;
      r_tx_data  <= w_tx_data_next;
      r_idx      <= w_idx_next;
      r_fifo_pop <= w_fifo_pop_next;
    end
  end

  assign o_rx_ready   = w_rx_ready;
  assign o_tx_valid   = (r_state == StSend);
  assign o_tx_data    = r_tx_data;
  assign o_fifo_pop   = r_fifo_pop;
  assign o_sensor_rst = (r_state == StRstPulse) ? w_idx_onehot : '0;

endmodule

// File: tb/tb_sensor_uart_scheduler.sv
// Scoreboard bench for sensor_uart_scheduler: expected TX bytes are queued per command
// and compared at each TX handshake.
module tb_sensor_uart_scheduler;

  localparam int unsigned DW = 8;
  localparam int unsigned NS = 8;
  localparam int unsigned T  = 20;
  localparam int unsigned P  = 4;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  logic             clk = 1'b0;
  logic             rst;
  logic [DW-1:0]    rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic [DW-1:0]    tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [NS-1:0]    fifo_valid;
  logic [NS*DW-1:0] fifo_data;
  logic [NS-1:0]    fifo_pop;
  logic [NS-1:0]    sensor_rst;

  sensor_uart_scheduler #(
    .DATA_DEPTH       (DW),
    .NUM_SENSORS      (NS),
    .DATA_CMD_BASE    (97),
    .RST_CMD_BASE     (105),
    .TIMEOUT_CYCLES   (T),
    .RST_PULSE_CYCLES (P)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .o_rx_ready   (rx_ready),
    .o_tx_data    (tx_data),
    .o_tx_valid   (tx_valid),
    .i_tx_ready   (tx_ready),
    .i_fifo_valid (fifo_valid),
    .i_fifo_data  (fifo_data),
    .o_fifo_pop   (fifo_pop),
    .o_sensor_rst (sensor_rst)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_cyc, first_valid_cyc, pop_cyc;
  int hs_cnt = 0, pop_cnt = 0, rst_cnt = 0, rst_multi = 0;
  logic [NS-1:0] last_pop = '0, last_rst = '0;
  logic          prev_valid = 1'b0;
  logic [7:0]    exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output monitor and scoreboard consumer.
  initial forever begin
    @(negedge clk);
    if (tx_valid && !prev_valid) first_valid_cyc = cyc;
    prev_valid = tx_valid;
    if (fifo_pop != '0) begin
      pop_cnt++;
      last_pop = fifo_pop;
      pop_cyc  = cyc;
    end
    if (sensor_rst != '0) begin
      rst_cnt++;
      last_rst = sensor_rst;
      if ($countones(sensor_rst) != 1) rst_multi++;
    end
    if (tx_valid && tx_ready) begin
      hs_cnt++;
      check_eq("tx_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check_eq("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic send_cmd(input logic [7:0] b);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (rx_ready) begin
        got     = 1'b1;
        acc_cyc = cyc;
      end
    end
    check_eq("rx_accept", 32'(got), 32'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx_done();
    for (int i = 0; i < int'(T) + 50 && exp_q.size() != 0; i++) @(negedge clk);
    check_eq("tx_done", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic wait_valid();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (tx_valid) ok = 1'b1;
    end
    check_eq("tx_valid_seen", 32'(ok), 32'd1);
  endtask

  task automatic pulse_reset_and_check(input string tag);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq({tag, "_txv"}, 32'(tx_valid), 32'd0);
    check_eq({tag, "_txd"}, 32'(tx_data), 32'd0);
    check_eq({tag, "_pop"}, 32'(fifo_pop), 32'd0);
    check_eq({tag, "_srst"}, 32'(sensor_rst), 32'd0);
    check_eq({tag, "_rdy"}, 32'(rx_ready), 32'd1);
  endtask

  logic [7:0]    tbl_cmd [5] = '{8'd96, 8'd104, 8'd105, 8'd112, 8'd113};
  logic [7:0]    tbl_exp [5] = '{NAK, 8'h17, ACK, ACK, NAK};
  logic [NS-1:0] tbl_pop [5] = '{8'h00, 8'h80, 8'h00, 8'h00, 8'h00};
  logic [NS-1:0] tbl_rst [5] = '{8'h00, 8'h00, 8'h01, 8'h80, 8'h00};

  initial begin
    int p0, r0, h0, bad;
    logic ok;
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b1;
    fifo_valid = '0; fifo_data = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_rdy", 32'(rx_ready), 32'd0);
    check_eq("rst_txv", 32'(tx_valid), 32'd0);
    check_eq("rst_txd", 32'(tx_data), 32'd0);
    check_eq("rst_pop", 32'(fifo_pop), 32'd0);
    check_eq("rst_srst", 32'(sensor_rst), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("idle_rdy", 32'(rx_ready), 32'd1);

    // Data read of sensor 2 with a ready FIFO.
    fifo_data[2*DW +: DW] = 8'h3C;
    fifo_valid = 8'b0000_0100;
    p0 = pop_cnt;
    exp_q.push_back(8'h3C);
    send_cmd(8'd99);
    wait_tx_done();
    check_eq("d2_latency", 32'(first_valid_cyc - acc_cyc), 32'd3);
    check_eq("d2_pop_cnt", 32'(pop_cnt - p0), 32'd1);
    check_eq("d2_pop_bit", 32'(last_pop), 32'h04);
    check_eq("d2_pop_cyc", 32'(pop_cyc), 32'(first_valid_cyc));
    @(posedge clk); #1 fifo_valid = '0;

    // Empty FIFO times out with NAK.
    p0 = pop_cnt;
    exp_q.push_back(NAK);
    send_cmd(8'd97);
    wait_tx_done();
    check_eq("to_latency", 32'(first_valid_cyc - acc_cyc), 32'(T + 2));
    check_eq("to_pop_cnt", 32'(pop_cnt - p0), 32'd0);

    // FIFO turns valid on the final wait cycle: data wins.
    fifo_data[0 +: DW] = 8'hA5;
    p0 = pop_cnt;
    exp_q.push_back(8'hA5);
    send_cmd(8'd97);
    ok = 1'b0;
    for (int i = 0; i < int'(T) + 10 && !ok; i++) begin
      @(negedge clk);
      if (cyc == acc_cyc + int'(T) + 1) ok = 1'b1;
    end
    fifo_valid[0] = 1'b1;
    wait_tx_done();
    check_eq("late_latency", 32'(first_valid_cyc - acc_cyc), 32'(T + 2));
    check_eq("late_pop_cnt", 32'(pop_cnt - p0), 32'd1);
    check_eq("late_pop_bit", 32'(last_pop), 32'h01);
    @(posedge clk); #1 fifo_valid = '0;

    // Reset of sensor 5.
    r0 = rst_cnt;
    exp_q.push_back(ACK);
    send_cmd(8'd110);
    wait_tx_done();
    check_eq("s5_rst_cycles", 32'(rst_cnt - r0), 32'(P));
    check_eq("s5_rst_bit", 32'(last_rst), 32'h20);
    check_eq("s5_rst_multi", 32'(rst_multi), 32'd0);
    check_eq("s5_latency", 32'(first_valid_cyc - acc_cyc), 32'(P + 2));

    // Range boundaries with every FIFO ready.
    for (int k = 0; k < int'(NS); k++) fifo_data[k*DW +: DW] = 8'(8'h10 + k);
    fifo_valid = '1;
    for (int t = 0; t < 5; t++) begin
      p0 = pop_cnt;
      r0 = rst_cnt;
      exp_q.push_back(tbl_exp[t]);
      send_cmd(tbl_cmd[t]);
      wait_tx_done();
      check_eq($sformatf("bnd%0d_pop", t), 32'(pop_cnt - p0), 32'(tbl_pop[t] != '0));
      check_eq($sformatf("bnd%0d_rst", t), 32'(rst_cnt - r0), (tbl_rst[t] != '0) ? P : 0);
      if (tbl_pop[t] != '0) check_eq($sformatf("bnd%0d_pbit", t), 32'(last_pop), 32'(tbl_pop[t]));
      if (tbl_rst[t] != '0) check_eq($sformatf("bnd%0d_rbit", t), 32'(last_rst), 32'(tbl_rst[t]));
    end
    @(posedge clk); #1 fifo_valid = '0;

    // Invalid command with back-pressured TX.
    @(posedge clk); #1 tx_ready = 1'b0;
    p0 = pop_cnt;
    r0 = rst_cnt;
    exp_q.push_back(NAK);
    send_cmd(8'h41);
    wait_valid();
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (tx_data != NAK || rx_ready || !tx_valid) bad++;
    end
    check_eq("bp_stable", 32'(bad), 32'd0);
    @(posedge clk); #1 tx_ready = 1'b1;
    wait_tx_done();
    check_eq("bp_pop_cnt", 32'(pop_cnt - p0), 32'd0);
    check_eq("bp_rst_cnt", 32'(rst_cnt - r0), 32'd0);

    // Reset during the second reset-pulse cycle.
    r0 = rst_cnt;
    h0 = hs_cnt;
    send_cmd(8'd110);
    for (int i = 0; i < 10 && cyc != acc_cyc + 2; i++) @(negedge clk);
    pulse_reset_and_check("rstp");
    repeat (10) @(negedge clk);
    check_eq("rstp_rst_cycles", 32'(rst_cnt - r0), 32'd2);
    check_eq("rstp_no_tx", 32'(hs_cnt - h0), 32'd0);

    // Reset while holding a byte in SEND.
    @(posedge clk); #1 tx_ready = 1'b0;
    h0 = hs_cnt;
    send_cmd(8'h41);
    wait_valid();
    pulse_reset_and_check("rsts");
    @(posedge clk); #1 tx_ready = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("rsts_no_tx", 32'(hs_cnt - h0), 32'd0);

    // Normal service after the aborts.
    fifo_data[2*DW +: DW] = 8'h3C;
    fifo_valid = 8'b0000_0100;
    p0 = pop_cnt;
    exp_q.push_back(8'h3C);
    send_cmd(8'd99);
    wait_tx_done();
    check_eq("post_latency", 32'(first_valid_cyc - acc_cyc), 32'd3);
    check_eq("post_pop_cnt", 32'(pop_cnt - p0), 32'd1);
    check_eq("post_pop_bit", 32'(last_pop), 32'h04);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
